// File: rtl/sd_cmd_rx.sv
// sd_cmd_rx: card-side SD CMD line receiver for 48-bit host frames.
// Build option: define SD_CMD_RX_CRC_CHECK_EN to include the CRC7 checker.
module sd_cmd_rx #(
  parameter bit CHECK_TX_BIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        CMD_IN,
  input  logic        CMD_ACK,
  output logic        CMD_VALID,
  output logic [5:0]  CMD_INDEX,
  output logic [31:0] CMD_ARG,
  output logic [6:0]  CMD_CRC,
  output logic        CRC_ERR,
  output logic        FRAME_ERR,
  output logic        OVERRUN,
  output logic        BUSY
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [46:0] shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_rx_q, crc_rx_d;
  logic        ferr_q, ferr_d;
  logic        start, done, load;

  always_comb begin
    start = (state_q == IDLE) && EN && !CMD_IN;
    done  = (state_q == SHIFT) && EN && (cnt_q == 6'd47);
    load  = done && (!valid_q || CMD_ACK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // shift_q[b-1] holds frame bit b once bit 1 has been sampled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = 6'd1;
          shift_d = {46'd0, CMD_IN};
        end
      end
      SHIFT: begin
        if (EN) begin
          shift_d = {shift_q[45:0], CMD_IN};
          if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      idx_q    <= '0;
      arg_q    <= '0;
      crc_rx_q <= '0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      crc_rx_q <= crc_rx_d;
      ferr_q   <= ferr_d;
    end
  end

  // A finished frame wins over a pending result only when acked on that edge
  always_comb begin
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    crc_rx_d = crc_rx_q;
    ferr_d   = ferr_q;
    if (load) begin
      valid_d  = 1'b1;
      ovr_d    = 1'b0;
      idx_d    = shift_q[44:39];
      arg_d    = shift_q[38:7];
      crc_rx_d = shift_q[6:0];
      ferr_d   = shift_q[46]
               || (CHECK_TX_BIT && !shift_q[45])
               || !CMD_IN;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (CMD_ACK && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

`ifdef SD_CMD_RX_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d;
  logic       crc_err_q, crc_err_d;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       b
  );
    logic inv;
    inv = b ^ c[6];
    return {c[5:3], c[2] ^ inv, c[1:0], inv};
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
    end
  end

  // Covers frame bits 47..8: start edge plus counter values 1..39
  always_comb begin
    crc_d     = crc_q;
    crc_err_d = crc_err_q;
    if (start) begin
      crc_d = crc7_step(7'd0, CMD_IN);
    end else if (state_q == SHIFT && EN && cnt_q <= 6'd39) begin
      crc_d = crc7_step(crc_q, CMD_IN);
    end
    if (load) begin
      crc_err_d = (crc_q != shift_q[6:0]);
    end
  end

  assign CRC_ERR = crc_err_q;
`else
  assign CRC_ERR = 1'b0;
`endif

  assign CMD_VALID = valid_q;
  assign CMD_INDEX = idx_q;
  assign CMD_ARG   = arg_q;
  assign CMD_CRC   = crc_rx_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = (state_q == SHIFT);

endmodule

// File: tb/tb_sd_cmd_rx.sv
// tb_sd_cmd_rx: table vectors, corner sequences and random frames
// checked against a frame-level model with a long-division CRC7.
module tb_sd_cmd_rx;
`ifdef SD_CMD_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, EN, CMD_IN, CMD_ACK;
  logic        CMD_VALID, CRC_ERR, FRAME_ERR, OVERRUN, BUSY;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  logic [6:0]  CMD_CRC;
  logic        d0_valid, d0_cerr, d0_ferr, d0_ovr, d0_busy;
  logic [5:0]  d0_idx;
  logic [31:0] d0_arg;
  logic [6:0]  d0_crc;

  sd_cmd_rx dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CMD_IN(CMD_IN),
    .CMD_ACK(CMD_ACK), .CMD_VALID(CMD_VALID),
    .CMD_INDEX(CMD_INDEX), .CMD_ARG(CMD_ARG),
    .CMD_CRC(CMD_CRC), .CRC_ERR(CRC_ERR),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  sd_cmd_rx #(.CHECK_TX_BIT(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .CMD_IN(CMD_IN),
    .CMD_ACK(CMD_ACK), .CMD_VALID(d0_valid),
    .CMD_INDEX(d0_idx), .CMD_ARG(d0_arg),
    .CMD_CRC(d0_crc), .CRC_ERR(d0_cerr),
    .FRAME_ERR(d0_ferr), .OVERRUN(d0_ovr), .BUSY(d0_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic        m_valid, m_ovr, m_busy;
  logic        m_cerr, m_ferr, m_ferr0;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  logic [6:0]  m_crc;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Remainder of d(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_busy = 0;
    m_cerr = 0; m_ferr = 0; m_ferr0 = 0;
    m_idx = '0; m_arg = '0; m_crc = '0;
  endtask

  task automatic model_load(input logic [47:0] f);
    m_idx   = f[45:40];
    m_arg   = f[39:8];
    m_crc   = f[7:1];
    m_cerr  = CRC_ON && (crc7_ref(f[47:8]) != f[7:1]);
    m_ferr  = f[47] || !f[46] || !f[0];
    m_ferr0 = f[47] || !f[0];
  endtask

  task automatic step(input logic en, input logic b, input logic ack,
                      input logic is_end, input logic [47:0] f);
    @(negedge CLK);
    EN = en; CMD_IN = b; CMD_ACK = ack;
    @(posedge CLK);
    #1;
    if (is_end) begin
      if (m_valid && !ack) m_ovr = 1;
      else begin
        model_load(f);
        m_valid = 1;
        m_ovr = 0;
      end
    end else if (ack && m_valid) begin
      m_valid = 0;
      m_ovr = 0;
    end
  endtask

  task automatic check_hs();
    chk("valid", CMD_VALID, m_valid);
    chk("overrun", OVERRUN, m_ovr);
    chk("busy", BUSY, m_busy);
  endtask

  task automatic check_all();
    check_hs();
    chk("valid_notx", d0_valid, m_valid);
    if (m_valid) begin
      chk("index", CMD_INDEX, m_idx);
      chk("arg", CMD_ARG, m_arg);
      chk("crc", CMD_CRC, m_crc);
      chk("crc_err", CRC_ERR, m_cerr);
      chk("frame_err", FRAME_ERR, m_ferr);
      chk("frame_err_notx", d0_ferr, m_ferr0);
    end
  endtask

  task automatic check_zero();
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_index", CMD_INDEX, 0);
    chk("rst_arg", CMD_ARG, 0);
    chk("rst_crc", CMD_CRC, 0);
    chk("rst_crc_err", CRC_ERR, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_busy", BUSY, 0);
  endtask

  // mode 0: EN every edge, 1: EN every other edge, 2: random EN gaps
  task automatic send_frame(input logic [47:0] f, input int mode,
                            input logic ack_end, input logic rand_ack);
    int gaps;
    logic a;
    for (int k = 0; k < 48; k++) begin
      gaps = (mode == 1) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        a = rand_ack && ($urandom_range(0, 3) == 0);
        step(0, f[47-k], a, 0, f);
        check_hs();
      end
      a = (k == 47) ? ack_end
                    : (rand_ack && ($urandom_range(0, 7) == 0));
      step(1, f[47-k], a, k == 47, f);
      m_busy = (k < 47);
      check_hs();
    end
  endtask

  task automatic ack_pulse();
    step(1, 1, 1, 0, '0);
    check_hs();
  endtask

  typedef struct {
    logic [47:0] f;
    int          mode;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        cerr;
    logic        ferr;
    logic        ferr0;
  } vec_t;

  localparam logic [47:0] CMD0 = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD8 = 48'h48_0000_01AA_87;

  initial begin
    vec_t vt[5];
    logic [47:0] f;
    logic [5:0]  ri;
    logic [31:0] ra;
    int          kind;

    vt[0] = '{CMD0, 0, 6'd0, 32'h0, 7'h4A, 1'b0, 1'b0, 1'b0};
    vt[1] = '{CMD8, 1, 6'd8, 32'h1AA, 7'h43, 1'b0, 1'b0, 1'b0};
    vt[2] = '{48'h48_0000_01AB_87, 0, 6'd8, 32'h1AB, 7'h43,
              CRC_ON, 1'b0, 1'b0};
    vt[3] = '{48'h40_0000_0000_94, 0, 6'd0, 32'h0, 7'h4A,
              1'b0, 1'b1, 1'b1};
    vt[4] = '{48'h00_0000_0000_01, 0, 6'd0, 32'h0, 7'h00,
              1'b0, 1'b1, 1'b0};

    RST = 1; EN = 0; CMD_IN = 1; CMD_ACK = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_zero();
    @(negedge CLK);
    RST = 0;
    step(1, 1, 0, 0, '0);
    check_all();

    for (int i = 0; i < 5; i++) begin
      send_frame(vt[i].f, vt[i].mode, 0, 0);
      chk("vec_valid", CMD_VALID, 1);
      chk("vec_index", CMD_INDEX, vt[i].idx);
      chk("vec_arg", CMD_ARG, vt[i].arg);
      chk("vec_crc", CMD_CRC, vt[i].crc);
      chk("vec_crc_err", CRC_ERR, vt[i].cerr);
      chk("vec_frame_err", FRAME_ERR, vt[i].ferr);
      chk("vec_frame_err_notx", d0_ferr, vt[i].ferr0);
      chk("vec_busy", BUSY, 0);
      ack_pulse();
      chk("vec_ack_valid", CMD_VALID, 0);
    end

    send_frame(CMD0, 0, 0, 0);
    send_frame(CMD8, 0, 0, 0);
    chk("ovr_index", CMD_INDEX, 0);
    chk("ovr_crc", CMD_CRC, 7'h4A);
    chk("ovr_set", OVERRUN, 1);
    chk("ovr_valid", CMD_VALID, 1);
    ack_pulse();
    chk("ovr_clr", OVERRUN, 0);
    chk("ovr_valid_clr", CMD_VALID, 0);

    send_frame(CMD0, 0, 0, 0);
    send_frame(CMD8, 0, 1, 0);
    chk("ackend_index", CMD_INDEX, 8);
    chk("ackend_arg", CMD_ARG, 32'h1AA);
    chk("ackend_valid", CMD_VALID, 1);
    chk("ackend_ovr", OVERRUN, 0);
    ack_pulse();

    send_frame(CMD8, 0, 0, 0);
    f = 48'h3F_FFFF_FFFF_FF;
    for (int k = 0; k <= 20; k++) begin
      step(1, f[47-k], 0, 0, f);
      m_busy = 1;
      check_hs();
    end
    @(negedge CLK);
    RST = 1;
    #1;
    model_reset();
    check_zero();
    @(negedge CLK);
    check_zero();
    RST = 0;
    send_frame(CMD0, 0, 0, 0);
    chk("rst_cmd0_index", CMD_INDEX, 0);
    chk("rst_cmd0_arg", CMD_ARG, 0);
    chk("rst_cmd0_crc", CMD_CRC, 7'h4A);
    chk("rst_cmd0_crc_err", CRC_ERR, 0);
    chk("rst_cmd0_frame_err", FRAME_ERR, 0);
    check_all();
    ack_pulse();

    for (int n = 0; n < 40; n++) begin
      ri = 6'($urandom);
      ra = $urandom;
      f = {2'b01, ri, ra, crc7_ref({2'b01, ri, ra}), 1'b1};
      kind = $urandom_range(0, 5);
      if (kind == 0) f[$urandom_range(1, 7)] ^= 1'b1;
      else if (kind == 1) f[0] = 1'b0;
      else if (kind == 2) f[46] = 1'b0;
      send_frame(f, $urandom_range(0, 2),
                 $urandom_range(0, 3) == 0, 1);
      check_all();
      for (int g = 0; g < $urandom_range(0, 3); g++) begin
        step($urandom_range(0, 1), 1,
             $urandom_range(0, 2) == 0, 0, '0);
        check_all();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
